seed_selector_m: RTL and testbench

Parametrised seed-selection block for the game datapath. Player navigates a bank of `N_SEEDS` game seeds with next/previous buttons, then requests a load; the block fetches the selected word from an external synchronous seed ROM, latches it, and locks it as the active game seed until cleared. It replaces the single-button, fixed-width seed logic in `fluxo_dados` and feeds `jogo_atual` and the debug address outputs.

---
 rtl/seed_selector_m.sv | 131 +++++++++++++
 tb/tb_seed_selector_m.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seed_selector_m.sv
// Seed selection for the game datapath: button navigation over a seed ROM, load, lock.
// Optional macro SEED_PREV_BTN_EN compiles in the "previous seed" button and decrement path.
module seed_selector_m #(
  parameter int N_SEEDS = 20,
  parameter int ADDR_W  = 5,
  parameter int SEED_W  = 10
) (
  input  logic              clock,
  input  logic              rst_global,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              zera,
  input  logic              load_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [SEED_W-1:0] rom_data,
  output logic [ADDR_W-1:0] seed_addr,
  output logic [SEED_W-1:0] seed_out,
  output logic              seed_valid,
  output logic              load_ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_SEEDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic              valid_q, valid_d;
  logic              ack_q, ack_d;
  logic              btn_next_q, btn_next_d;
  logic              next_edge;
  logic              prev_edge;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] nav_addr;

  assign btn_next_d = btn_next;
  assign next_edge  = btn_next & ~btn_next_q;

  // Wrap is an explicit compare so non-power-of-two banks never alias.
  assign addr_inc = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;

`ifdef SEED_PREV_BTN_EN
  logic              btn_prev_q, btn_prev_d;
  logic [ADDR_W-1:0] addr_dec;

  assign btn_prev_d = btn_prev;
  assign prev_edge  = btn_prev & ~btn_prev_q;
  assign addr_dec   = (addr_q == '0) ? ADDR_LAST : addr_q - ADDR_ONE;

  always_ff @(posedge clock or posedge rst_global) begin
    if (rst_global) btn_prev_q <= 1'b0;
    else            btn_prev_q <= btn_prev_d;
  end

  // Opposing edges in the same cycle cancel out.
  always_comb begin
    nav_addr = addr_q;
    if (next_edge && !prev_edge)      nav_addr = addr_inc;
    else if (prev_edge && !next_edge) nav_addr = addr_dec;
  end
`else
  logic unused_btn_prev;

  assign unused_btn_prev = btn_prev;
  assign prev_edge       = 1'b0;

  always_comb begin
    nav_addr = addr_q;
    if (next_edge) nav_addr = addr_inc;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    if (zera) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      seed_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A load request freezes the address; same-cycle edges are dropped.
          if (load_req) state_d = ST_FETCH;
          else          addr_d  = nav_addr;
        end
        ST_FETCH: begin
          seed_d  = rom_data;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_LOCKED;
        end
        ST_LOCKED: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst_global) begin
    if (rst_global) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      seed_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      btn_next_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seed_q     <= seed_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      btn_next_q <= btn_next_d;
    end
  end

  assign rom_addr   = addr_q;
  assign seed_addr  = addr_q;
  assign seed_out   = seed_q;
  assign seed_valid = valid_q;
  assign load_ack   = ack_q;

endmodule

// File: tb/tb_seed_selector_m.sv
// Directed bench for seed_selector_m with a behavioural 1-cycle-latency seed ROM.
module tb_seed_selector_m;

  localparam int N_SEEDS = 20;
  localparam int ADDR_W  = 5;
  localparam int SEED_W  = 10;

  logic              clock = 1'b0;
  logic              rst_global;
  logic              btn_next, btn_prev, zera, load_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [SEED_W-1:0] rom_data;
  logic [ADDR_W-1:0] seed_addr;
  logic [SEED_W-1:0] seed_out;
  logic              seed_valid, load_ack;

  logic [SEED_W-1:0] rom [0:31];
  int n_checks = 0;
  int n_errors = 0;
  int exp_addr;

  seed_selector_m #(.N_SEEDS(N_SEEDS), .ADDR_W(ADDR_W), .SEED_W(SEED_W)) dut (
    .clock(clock), .rst_global(rst_global), .btn_next(btn_next), .btn_prev(btn_prev),
    .zera(zera), .load_req(load_req), .rom_addr(rom_addr), .rom_data(rom_data),
    .seed_addr(seed_addr), .seed_out(seed_out), .seed_valid(seed_valid), .load_ack(load_ack)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    tick();
  endtask

  task automatic do_zera();
    zera = 1'b1;
    tick();
    zera = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(seed_addr), 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_seed"}, 32'(seed_out), 32'd0);
    chk({tag, "_valid"}, 32'(seed_valid), 32'd0);
    chk({tag, "_ack"}, 32'(load_ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = SEED_W'((i * 53 + 17) & 10'h3FF);
    rom[7] = 10'h2A5;
    rom[3] = 10'h0B0;
    rst_global = 1'b1;
    btn_next = 1'b0; btn_prev = 1'b0; zera = 1'b0; load_req = 1'b0;

    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst_global = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // 21 presses walk through the whole bank and wrap once.
    exp_addr = 0;
    for (int i = 0; i < 21; i++) begin
      press_next();
      exp_addr = (exp_addr == N_SEEDS - 1) ? 0 : exp_addr + 1;
      chk("nav_next", 32'(seed_addr), 32'(exp_addr));
    end
    chk("nav_final", 32'(seed_addr), 32'd1);
    chk("rom_addr_follow", 32'(rom_addr), 32'd1);

    btn_next = 1'b1;
    tick();
    chk("held_first", 32'(seed_addr), 32'd2);
    tick(); tick(); tick();
    chk("held_still", 32'(seed_addr), 32'd2);
    btn_next = 1'b0;
    tick();

    do_zera();
    chk("zera_addr", 32'(seed_addr), 32'd0);

    btn_prev = 1'b1;
    tick();
    btn_prev = 1'b0;
    tick();
`ifdef SEED_PREV_BTN_EN
    chk("prev_wrap", 32'(seed_addr), 32'd19);
`else
    chk("prev_ignored", 32'(seed_addr), 32'd0);
`endif
    do_zera();

    // Load of word 7.
    for (int i = 0; i < 7; i++) press_next();
    chk("addr7", 32'(seed_addr), 32'd7);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("fetch_valid", 32'(seed_valid), 32'd0);
    chk("fetch_ack", 32'(load_ack), 32'd0);
    tick();
    chk("load_seed", 32'(seed_out), 32'h2A5);
    chk("load_valid", 32'(seed_valid), 32'd1);
    chk("load_ack_hi", 32'(load_ack), 32'd1);
    tick();
    chk("load_ack_lo", 32'(load_ack), 32'd0);
    chk("locked_valid", 32'(seed_valid), 32'd1);

    // Locked: buttons and load requests ignored.
    for (int i = 0; i < 3; i++) begin
      press_next();
      chk("locked_ack", 32'(load_ack), 32'd0);
    end
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("locked_req_ack", 32'(load_ack), 32'd0);
    tick();
    chk("locked_req_ack2", 32'(load_ack), 32'd0);
    tick();
    chk("locked_ack3", 32'(load_ack), 32'd0);
    chk("locked_addr", 32'(seed_addr), 32'd7);
    chk("locked_seed", 32'(seed_out), 32'h2A5);
    do_zera();
    chk("unlock_addr", 32'(seed_addr), 32'd0);
    chk("unlock_seed", 32'(seed_out), 32'd0);
    chk("unlock_valid", 32'(seed_valid), 32'd0);

    // Simultaneous edges at address 5.
    for (int i = 0; i < 5; i++) press_next();
    btn_next = 1'b1; btn_prev = 1'b1;
    tick();
    btn_next = 1'b0; btn_prev = 1'b0;
`ifdef SEED_PREV_BTN_EN
    chk("both_edges", 32'(seed_addr), 32'd5);
`else
    chk("both_edges", 32'(seed_addr), 32'd6);
`endif
    tick();

    // Button edge in the same cycle as the accepted load request is dropped, then zera aborts.
    btn_next = 1'b1;
    load_req = 1'b1;
    tick();
    btn_next = 1'b0;
    load_req = 1'b0;
`ifdef SEED_PREV_BTN_EN
    chk("req_edge_drop", 32'(seed_addr), 32'd5);
`else
    chk("req_edge_drop", 32'(seed_addr), 32'd6);
`endif
    zera = 1'b1;
    tick();
    zera = 1'b0;
    chk("abort_ack", 32'(load_ack), 32'd0);
    chk("abort_valid", 32'(seed_valid), 32'd0);
    chk("abort_seed", 32'(seed_out), 32'd0);
    chk("abort_addr", 32'(seed_addr), 32'd0);
    tick();
    chk("abort_ack2", 32'(load_ack), 32'd0);
    press_next();
    chk("abort_idle_nav", 32'(seed_addr), 32'd1);

    // Asynchronous reset in the middle of a fetch.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    #3 rst_global = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #1 rst_global = 1'b0;
    tick();
    chk("async_rst_ack", 32'(load_ack), 32'd0);
    chk("async_rst_valid", 32'(seed_valid), 32'd0);
    chk("async_rst_addr", 32'(seed_addr), 32'd0);

    for (int i = 0; i < 3; i++) press_next();
    chk("reload_addr", 32'(seed_addr), 32'd3);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    chk("reload_seed", 32'(seed_out), 32'h0B0);
    chk("reload_valid", 32'(seed_valid), 32'd1);
    chk("reload_ack", 32'(load_ack), 32'd1);
    tick();
    chk("reload_ack_lo", 32'(load_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
